// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer
//   Multi-cycle control FSM for a single-ported MIPS datapath.
//   Each instruction steps through FETCH -> DECODE -> EXEC -> MEM -> WB, and
//   skips any stage it does not need. The one memory port is shared between
//   instruction fetch and data access.
//
//   Optional feature: define SEQ_PERF_CNT_EN to build the saturating
//   performance counters. Without it, cycle_cnt and retire_cnt are tied to 0.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   run                 level: leave IDLE / keep fetching while high
//   mem_read .. halt    decoded control from the instruction decoder
//   br_taken            branch condition, valid in EXEC
//   mem_ready           memory handshake completion
//   mem_req/we/sel      memory request, write, address select (0 = PC, 1 = ALU)
//   ir_we, mdr_we       instruction / memory data register latch strobes
//   rf_we, pc_we        register file write, PC update (one per retired instr)
//   pc_src              00 PC+4, 01 branch target, 10 jump target, 11 rs
//   busy/halted/fault   state != IDLE / in HALT / in FAULT
//   cycle_cnt           non-IDLE cycles (performance counter)
//   retire_cnt          pc_we pulses (performance counter)
module multicycle_sequencer #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic             mem_read,
   input  logic             mem_write,
   input  logic             reg_write,
   input  logic             branch,
   input  logic             br_taken,
   input  logic             jump,
   input  logic             is_jal,
   input  logic             is_jr,
   input  logic             halt,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             mem_we,
   output logic             mem_sel,
   output logic             ir_we,
   output logic             mdr_we,
   output logic             rf_we,
   output logic             pc_we,
   output logic [1:0]       pc_src,
   output logic             busy,
   output logic             halted,
   output logic             fault,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] retire_cnt
);

   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_FAULT
   } state_t;

   state_t              state_reg, state_next;
   logic [WAIT_W-1:0]   wait_cnt_reg;
   logic                timeout;

   // The last allowed wait cycle: another cycle without mem_ready means FAULT.
   assign timeout = (wait_cnt_reg == WAIT_W'(MEM_TIMEOUT - 1)) && !mem_ready;

   always_comb begin
      state_next = state_reg;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_sel    = 1'b0;
      ir_we      = 1'b0;
      mdr_we     = 1'b0;
      rf_we      = 1'b0;
      pc_we      = 1'b0;
      pc_src     = 2'b00;
      case (state_reg)
         S_IDLE: begin
            if (run) state_next = S_FETCH;
         end
         S_FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               ir_we      = 1'b1;
               state_next = S_DECODE;
            end else if (timeout) begin
               state_next = S_FAULT;
            end
         end
         S_DECODE: begin
            if (halt) begin
               state_next = S_HALT;
            end else if (jump) begin
               pc_we  = 1'b1;
               pc_src = 2'b10;
               rf_we  = is_jal;
            end else if (is_jr) begin
               pc_we  = 1'b1;
               pc_src = 2'b11;
            end else begin
               state_next = S_EXEC;
            end
         end
         S_EXEC: begin
            if (branch) begin
               pc_we  = 1'b1;
               pc_src = br_taken ? 2'b01 : 2'b00;
            end else if (mem_read || mem_write) begin
               state_next = S_MEM;
            end else if (reg_write) begin
               state_next = S_WB;
            end else begin
               pc_we = 1'b1;
            end
         end
         S_MEM: begin
            mem_req = 1'b1;
            mem_sel = 1'b1;
            mem_we  = mem_write;
            if (mem_ready) begin
               if (mem_write) begin
                  pc_we = 1'b1;
               end else begin
                  mdr_we     = 1'b1;
                  state_next = S_WB;
               end
            end else if (timeout) begin
               state_next = S_FAULT;
            end
         end
         S_WB: begin
            rf_we = 1'b1;
            pc_we = 1'b1;
         end
         default: ;   // HALT and FAULT absorb until reset
      endcase
      // Every retiring cycle picks the next state from run alone.
      if (pc_we) state_next = run ? S_FETCH : S_IDLE;
   end

   assign busy   = (state_reg != S_IDLE);
   assign halted = (state_reg == S_HALT);
   assign fault  = (state_reg == S_FAULT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= S_IDLE;
         wait_cnt_reg <= '0;
      end else begin
         state_reg <= state_next;
         if ((state_next != state_reg) &&
             (state_next == S_FETCH || state_next == S_MEM))
            wait_cnt_reg <= '0;
         else if (mem_req && !mem_ready)
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
      end
   end

`ifdef SEQ_PERF_CNT_EN
   logic [CNT_W-1:0] cycle_cnt_reg, retire_cnt_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         cycle_cnt_reg  <= '0;
         retire_cnt_reg <= '0;
      end else begin
         if (busy && !(&cycle_cnt_reg))
            cycle_cnt_reg <= cycle_cnt_reg + 1'b1;
         if (pc_we && !(&retire_cnt_reg))
            retire_cnt_reg <= retire_cnt_reg + 1'b1;
      end
   end

   assign cycle_cnt  = cycle_cnt_reg;
   assign retire_cnt = retire_cnt_reg;
`else
   assign cycle_cnt  = '0;
   assign retire_cnt = '0;
`endif

endmodule
